equiv_lockstep_checker: RTL and testbench
=========================================

Name: equiv_lockstep_checker

Overview:
- Self-running spec-vs-impl equivalence checker for VL systest benches.
- Generates pseudo-random stimulus for a DUT pair and waits a programmable settle time per vector.
- Compares NCHAN output channels with 4-state case equality and accumulates mismatch statistics.
- Captures the first failing vector and reports sticky pass/fail and done status to the bench top.

Parameters:
- WIDTH, 41: bits per compared output channel.
- NCHAN, 5: number of output channels compared.
- IN_WIDTH, 12: stimulus width. Legal range 1..32.
- NVEC, 1000: vectors per run. Must be ≥1.
- SETTLE, 1: cycles between stimulus update and compare. Must be ≥1.
- MAX_FAILS, 32'hFFFF_FFFF: saturation value of fail_count.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- stop_on_fail  in  1  end the run at the first failing vector; sampled each CHECK cycle.
- seed  in  32  LFSR seed, loaded on an accepted start.
- spec_bus  in  NCHAN*WIDTH  spec outputs; channel c occupies [c*WIDTH +: WIDTH].
- impl_bus  in  NCHAN*WIDTH  impl outputs, same packing as spec_bus.
- stim  out  IN_WIDTH  stimulus to both DUTs.
- busy  out  1  high in LOAD/SETTLE/CHECK.
- done  out  1  high in DONE.
- pass  out  1  done && fail_count==0.
- vec_count  out  32  vectors checked this run.
- fail_count  out  32  failing vectors; saturates at MAX_FAILS.
- fail_chan_mask  out  NCHAN  sticky OR of per-channel mismatch over the run.
- first_fail_vec  out  32  0-based index of first failing vector.
- first_fail_stim  out  IN_WIDTH  stim of first failing vector.
- first_fail_chans  out  NCHAN  mismatching channels of first failing vector.
- first_fail_valid  out  1  first_fail_* fields are valid.

Behaviour:
- Reset: state IDLE; every output 0, including stim; lfsr=0; settle_cnt=0. Reset mid-run aborts immediately with no partial results kept.
- LFSR: 32-bit Galois, right-shift. next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0). Seed 0 is replaced by 1.
- IDLE: start → load lfsr from the (fixed-up) seed; clear vec_count, fail_count, fail_chan_mask and all first_fail_*; go to LOAD.
- LOAD: lfsr<=next(lfsr); stim<=next(lfsr)[IN_WIDTH-1:0]; settle_cnt<=SETTLE-1; go to SETTLE.
- SETTLE: settle_cnt==0 → CHECK, else decrement. stim is stable for SETTLE+1 cycles before the compare.
- CHECK, per-channel mismatch: mm[c] = (impl chan c !== spec chan c), 4-state. X/Z must match exactly: X vs X passes, X vs 0 fails, Z vs X fails.
- CHECK, counters: vec_count++. If |mm: fail_count++ (held at MAX_FAILS), fail_chan_mask|=mm.
- CHECK, first failure: if |mm and !first_fail_valid, capture first_fail_vec=vec_count (pre-increment), first_fail_stim=stim, first_fail_chans=mm, and set first_fail_valid.
- CHECK, exit: go to DONE if the new vec_count==NVEC or (stop_on_fail && |mm); otherwise go to LOAD.
- Cycle budget: each vector takes 2+SETTLE cycles. A clean run reaches DONE NVEC*(2+SETTLE) edges after the start-sampling edge.
- DONE: done=1 and all results held. start → same actions as start in IDLE. stim holds its last value.
- start while busy is ignored.
- stop_on_fail may toggle mid-run; only its value in CHECK matters.
- rst and start in the same cycle: rst wins.

Test Plan:
- NVEC=4, SETTLE=1, seed=0, impl_bus=spec_bus → first stim=12'h003; done rises 12 edges after start; pass=1, vec_count=4, fail_count=0, first_fail_valid=0.
- NVEC=8, stop_on_fail=0, bit 7 of channel 2 inverted during vector 3 only → fail_count=1, fail_chan_mask=5'b00100, first_fail_vec=3, first_fail_chans=5'b00100, pass=0, vec_count=8.
- Channel 0 both sides X in all bits → no failure. Then spec X vs impl 0 on vector 0 → first_fail_chans=5'b00001, first_fail_vec=0.
- stop_on_fail=1, channels 1 and 4 differ on every vector → DONE after vector 0; vec_count=1, fail_count=1, first_fail_chans=5'b10010.
- rst asserted during SETTLE of vector 5 → next cycle all outputs 0 and state IDLE. A new start with the same seed reproduces an identical stim sequence.
- MAX_FAILS=3, NVEC=6, every vector fails → fail_count=3, vec_count=6. start issued in DONE restarts and clears all results.

Source files
------------

// File: rtl/equiv_lockstep_checker_if.sv
// Bus between the lockstep checker and the spec/impl DUT pair.
//   stim      : stimulus driven by the checker to both DUTs
//   spec_bus  : spec outputs, channel c at [c*WIDTH +: WIDTH]
//   impl_bus  : impl outputs, same packing as spec_bus
// The checker takes the master modport and the DUT-pair side takes the slave modport.
interface equiv_lockstep_checker_if #(
  parameter int unsigned WIDTH    = 41,
  parameter int unsigned NCHAN    = 5,
  parameter int unsigned IN_WIDTH = 12
);
  logic [IN_WIDTH-1:0]    stim;
  logic [NCHAN*WIDTH-1:0] spec_bus;
  logic [NCHAN*WIDTH-1:0] impl_bus;

  modport master (output stim, input spec_bus, input impl_bus);
  modport slave  (input stim, output spec_bus, output impl_bus);
endinterface

// File: rtl/equiv_lockstep_checker.sv
// Self-running spec-vs-impl equivalence checker.
// For each vector it steps a 32-bit Galois LFSR, drives the low IN_WIDTH bits
// as stimulus, and waits SETTLE cycles. It then compares every output channel
// with 4-state case equality and accumulates the run statistics.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start             : run request, accepted only in IDLE or DONE
//   stop_on_fail      : end the run at the first failing vector (sampled in CHECK)
//   seed              : LFSR seed loaded on an accepted start (0 is replaced by 1)
//   bus               : stim out, spec_bus/impl_bus in
//   busy, done, pass  : run status
//   vec_count, fail_count, fail_chan_mask : run statistics
//   first_fail_*      : capture of the first failing vector
//   dbg_state         : current FSM state
// Handshake: start is a level sampled on each rising edge while the FSM is in
// IDLE or DONE. There is no ready signal: acceptance is visible as busy rising
// one cycle later. A start sampled while busy is dropped.
module equiv_lockstep_checker #(
  parameter int unsigned WIDTH     = 41,
  parameter int unsigned NCHAN     = 5,
  parameter int unsigned IN_WIDTH  = 12,
  parameter int unsigned NVEC      = 1000,
  parameter int unsigned SETTLE    = 1,
  parameter logic [31:0] MAX_FAILS = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop_on_fail,
  input  logic [31:0]         seed,
  equiv_lockstep_checker_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [31:0]         vec_count,
  output logic [31:0]         fail_count,
  output logic [NCHAN-1:0]    fail_chan_mask,
  output logic [31:0]         first_fail_vec,
  output logic [IN_WIDTH-1:0] first_fail_stim,
  output logic [NCHAN-1:0]    first_fail_chans,
  output logic                first_fail_valid,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [31:0] lfsr, lfsr_nx;
  logic [31:0] settle_cnt;
  logic [NCHAN-1:0] mm;
  logic        any_mm;
  logic        vec_last;
  logic        accept;

  // Galois right-shift step, taps 0x8020_0003.
  assign lfsr_nx  = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign vec_last = (vec_count + 32'd1) == 32'(NVEC);
  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign any_mm   = |mm;
  assign pass     = done && (fail_count == 32'd0);
  assign dbg_state = state;

  // Case inequality so X/Z must match bit-for-bit between spec and impl.
  always_comb begin
    mm = '0;
    for (int c = 0; c < int'(NCHAN); c++) begin
      mm[c] = (bus.impl_bus[c*WIDTH +: WIDTH] !== bus.spec_bus[c*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 32'd0) state_nx = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (vec_last || (stop_on_fail && any_mm)) state_nx = S_DONE;
        else                                      state_nx = S_LOAD;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr             <= '0;
      settle_cnt       <= '0;
      bus.stim         <= '0;
      vec_count        <= '0;
      fail_count       <= '0;
      fail_chan_mask   <= '0;
      first_fail_vec   <= '0;
      first_fail_stim  <= '0;
      first_fail_chans <= '0;
      first_fail_valid <= 1'b0;
    end else if (accept) begin
      // stim is deliberately not cleared so it holds across a restart from DONE.
      lfsr             <= (seed == 32'd0) ? 32'd1 : seed;
      vec_count        <= '0;
      fail_count       <= '0;
      fail_chan_mask   <= '0;
      first_fail_vec   <= '0;
      first_fail_stim  <= '0;
      first_fail_chans <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          lfsr       <= lfsr_nx;
          bus.stim   <= lfsr_nx[IN_WIDTH-1:0];
          settle_cnt <= 32'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (settle_cnt != 32'd0) settle_cnt <= settle_cnt - 32'd1;
        end
        S_CHECK: begin
          vec_count <= vec_count + 32'd1;
          if (any_mm) begin
            if (fail_count != MAX_FAILS) fail_count <= fail_count + 32'd1;
            fail_chan_mask <= fail_chan_mask | mm;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec_count;
              first_fail_stim  <= bus.stim;
              first_fail_chans <= mm;
              first_fail_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_lockstep_checker.sv
module tb_equiv_lockstep_checker;
  localparam int W  = 41;
  localparam int NC = 5;
  localparam int IW = 12;
  localparam int NV = 8;
  localparam int ST = 1;
  localparam logic [31:0] MF = 32'd3;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        stop_on_fail = 1'b0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, first_fail_valid;
  logic [31:0] vec_count, fail_count, first_fail_vec;
  logic [NC-1:0] fail_chan_mask, first_fail_chans;
  logic [IW-1:0] first_fail_stim;
  logic [2:0]  dbg_state;

  equiv_lockstep_checker_if #(.WIDTH(W), .NCHAN(NC), .IN_WIDTH(IW)) bus_if ();

  equiv_lockstep_checker #(
    .WIDTH(W), .NCHAN(NC), .IN_WIDTH(IW), .NVEC(NV), .SETTLE(ST), .MAX_FAILS(MF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail), .seed(seed),
    .bus(bus_if), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .fail_count(fail_count), .fail_chan_mask(fail_chan_mask),
    .first_fail_vec(first_fail_vec), .first_fail_stim(first_fail_stim),
    .first_fail_chans(first_fail_chans), .first_fail_valid(first_fail_valid),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- emulated DUT pair ----------------
  int            scen   = 0;
  logic [IW-1:0] target = '0;
  logic [NC*W-1:0] sp_w, im_w;

  function automatic void pair_out(input logic [IW-1:0] s, input int sc, input logic [IW-1:0] tg,
                                   output logic [NC*W-1:0] sp, output logic [NC*W-1:0] im);
    for (int c = 0; c < NC; c++) sp[c*W +: W] = {s, ~s, s, 5'(c)};
    im = sp;
    case (sc)
      1: if (s == tg) im[2*W+7] = ~im[2*W+7];
      2: begin sp[W-1:0] = {W{1'bx}}; im[W-1:0] = {W{1'bx}}; end
      3: begin sp[W-1:0] = {W{1'bx}}; im[W-1:0] = '0; end
      4: begin im[W+3] = ~im[W+3]; im[4*W+40] = ~im[4*W+40]; end
      5: for (int c = 0; c < NC; c++) if (tg[c] && s[c+3]) im[c*W+c*7] = ~im[c*W+c*7];
      6: im[0] = ~im[0];
      default: ;
    endcase
  endfunction

  always_comb pair_out(bus_if.stim, scen, target, sp_w, im_w);
  assign bus_if.spec_bus = sp_w;
  assign bus_if.impl_bus = im_w;

  // ---------------- reference model / scoreboard ----------------
  logic [IW-1:0] exp_q[$];
  logic [31:0]   e_vec, e_fail, e_ffv;
  logic [NC-1:0] e_mask, e_ffc;
  logic [IW-1:0] e_ffs;
  logic          e_ffvalid;

  function automatic logic [31:0] lfsr_ref(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic model_run(input logic [31:0] sd, input logic stp);
    logic [31:0] s;
    int fails;
    logic [NC*W-1:0] sp, im;
    logic [NC-1:0] mm;
    logic [IW-1:0] st;
    exp_q.delete();
    s = (sd == 32'd0) ? 32'd1 : sd;
    fails = 0; e_vec = 0; e_mask = '0; e_ffvalid = 1'b0; e_ffv = '0; e_ffs = '0; e_ffc = '0;
    for (int i = 0; i < NV; i++) begin
      s  = lfsr_ref(s);
      st = s[IW-1:0];
      exp_q.push_back(st);
      pair_out(st, scen, target, sp, im);
      for (int c = 0; c < NC; c++) mm[c] = (im[c*W +: W] !== sp[c*W +: W]);
      e_vec = 32'(i + 1);
      if (mm != '0) begin
        fails++;
        e_mask = e_mask | mm;
        if (!e_ffvalid) begin e_ffvalid = 1'b1; e_ffv = 32'(i); e_ffs = st; e_ffc = mm; end
      end
      if (stp && mm != '0) break;
    end
    e_fail = (32'(fails) > MF) ? MF : 32'(fails);
  endtask

  // ---------------- driver + checks for one run ----------------
  task automatic run_scenario(input string nm, input logic [31:0] sd, input logic stp, input int poke);
    int k;
    bit seen;
    logic [IW-1:0] want;
    model_run(sd, stp);
    @(negedge clk);
    seed = sd; stop_on_fail = stp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || vec_count !== 32'd0 || fail_count !== 32'd0 ||
        fail_chan_mask !== '0 || first_fail_valid !== 1'b0 || first_fail_vec !== 32'd0 ||
        first_fail_chans !== '0 || first_fail_stim !== '0) begin
      n_fail++;
      $display("FAIL %s cleared_on_start got busy=%b done=%b vec=%0d fails=%0d mask=%b ffvalid=%b want busy=1 done=0 and zeroed results",
               nm, busy, done, vec_count, fail_count, fail_chan_mask, first_fail_valid);
    end
    seen = 0;
    for (k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == poke) begin start = 1'b1; seed = sd ^ 32'h1357_9bdf; end
      else start = 1'b0;
      if (dbg_state == ST_CHECK) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s stim got extra vector stim=%h want no more vectors", nm, bus_if.stim);
        end else begin
          want = exp_q.pop_front();
          if (bus_if.stim !== want) begin
            n_fail++;
            $display("FAIL %s stim got %h want %h", nm, bus_if.stim, want);
          end
        end
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin seen = 1; break; end
    end
    start = 1'b0; seed = sd;
    n_checks++;
    if (!seen || k != int'(e_vec) * (2 + ST)) begin
      n_fail++;
      $display("FAIL %s done_latency got seen=%0d edges=%0d want %0d", nm, seen, k, int'(e_vec) * (2 + ST));
    end
    n_checks++;
    if (vec_count !== e_vec) begin n_fail++; $display("FAIL %s vec_count got %0d want %0d", nm, vec_count, e_vec); end
    n_checks++;
    if (fail_count !== e_fail) begin n_fail++; $display("FAIL %s fail_count got %0d want %0d", nm, fail_count, e_fail); end
    n_checks++;
    if (fail_chan_mask !== e_mask) begin n_fail++; $display("FAIL %s fail_chan_mask got %b want %b", nm, fail_chan_mask, e_mask); end
    n_checks++;
    if (first_fail_valid !== e_ffvalid) begin n_fail++; $display("FAIL %s first_fail_valid got %b want %b", nm, first_fail_valid, e_ffvalid); end
    n_checks++;
    if (first_fail_vec !== e_ffv) begin n_fail++; $display("FAIL %s first_fail_vec got %0d want %0d", nm, first_fail_vec, e_ffv); end
    n_checks++;
    if (first_fail_stim !== e_ffs) begin n_fail++; $display("FAIL %s first_fail_stim got %h want %h", nm, first_fail_stim, e_ffs); end
    n_checks++;
    if (first_fail_chans !== e_ffc) begin n_fail++; $display("FAIL %s first_fail_chans got %b want %b", nm, first_fail_chans, e_ffc); end
    n_checks++;
    if (pass !== (e_fail == 32'd0) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pass_busy got pass=%b busy=%b want pass=%b busy=0", nm, pass, busy, e_fail == 32'd0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s vectors_missing got %0d unchecked want 0", nm, exp_q.size()); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; seed = 32'hdead_beef;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, pass, vec_count, fail_count, fail_chan_mask, first_fail_vec, first_fail_stim,
         first_fail_chans, first_fail_valid, bus_if.stim, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b done=%b vec=%0d stim=%h state=%0d want all zero",
               busy, done, vec_count, bus_if.stim, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got state=%0d busy=%b want 0 0", dbg_state, busy);
    end
  endtask

  task automatic test_clean_run();
    scen = 0;
    run_scenario("clean_seed0", 32'd0, 1'b0, 0);
  endtask

  task automatic test_single_fault();
    logic [31:0] s;
    s = 32'd1;
    for (int i = 0; i < 4; i++) s = lfsr_ref(s);
    scen = 1; target = s[IW-1:0];
    run_scenario("single_fault_vec3", 32'd0, 1'b0, 0);
  endtask

  task automatic test_x_compare();
    scen = 2;
    run_scenario("x_vs_x", 32'h0000_1234, 1'b0, 0);
    scen = 3;
    run_scenario("x_vs_zero", 32'h0000_1234, 1'b0, 0);
  endtask

  task automatic test_stop_on_fail();
    scen = 4;
    run_scenario("stop_on_fail", 32'hcafe_f00d, 1'b1, 0);
  endtask

  task automatic test_saturation_and_restart();
    scen = 6;
    run_scenario("saturate", 32'h0bad_1dea, 1'b0, 0);
    scen = 0;
    run_scenario("restart_from_done", 32'h0bad_1dea, 1'b0, 0);
  endtask

  task automatic test_reset_mid_run();
    bit hit;
    scen = 0; hit = 0;
    @(negedge clk);
    seed = 32'h7777_0001; stop_on_fail = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (dbg_state == ST_SETTLE && vec_count == 32'd5) begin hit = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL reach_vec5_settle got state=%0d vec=%0d want 2 5", dbg_state, vec_count); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, pass, vec_count, fail_count, fail_chan_mask, first_fail_vec, first_fail_stim,
         first_fail_chans, first_fail_valid, bus_if.stim, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL mid_run_reset got busy=%b vec=%0d stim=%h state=%0d want all zero",
               busy, vec_count, bus_if.stim, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    run_scenario("replay_after_reset", 32'h7777_0001, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      scen   = 5;
      target = IW'($urandom);
      run_scenario($sformatf("random_%0d", r), $urandom, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_single_fault();
    test_x_compare();
    test_stop_on_fail();
    test_saturation_and_restart();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
